// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage. It stalls the pipeline
// until {remainder, quotient} is ready. Signed operands are divided as magnitudes.
module ex_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    S_FREE    = 2'b00,
    S_BY_ZERO = 2'b01,
    S_ON      = 2'b10,
    S_END     = 2'b11
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*DATA_W:0]   r_work;
  logic [DATA_W-1:0]   r_divisor;
  logic                r_sign_q, r_sign_r;
  logic [2*DATA_W-1:0] r_result;

  logic [DATA_W-1:0]   w_op1_abs, w_op2_abs;
  logic [DATA_W:0]     w_trial;
  logic [2*DATA_W:0]   w_work_nxt;
  logic [DATA_W-1:0]   w_quot, w_rem;
  logic                w_last, w_accept;

  assign w_op1_abs = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign w_op2_abs = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
  assign w_accept  = start_i && !annul_i;
  assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));

  // Working register: [2W:W+1] partial remainder, [W:1] dividend bits still to
  // be consumed, quotient bits shift in at the bottom.
  assign w_trial    = {1'b0, r_work[2*DATA_W-1:DATA_W]} - {1'b0, r_divisor};
  assign w_work_nxt = w_trial[DATA_W] ? {r_work[2*DATA_W-1:0], 1'b0}
                                      : {w_trial[DATA_W-1:0], r_work[DATA_W-1:0], 1'b1};

  assign w_quot = r_sign_q ? -w_work_nxt[DATA_W-1:0] : w_work_nxt[DATA_W-1:0];
  assign w_rem  = r_sign_r ? -w_work_nxt[2*DATA_W:DATA_W+1] : w_work_nxt[2*DATA_W:DATA_W+1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_FREE: begin
        if (w_accept) w_state_nxt = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
      end
      S_BY_ZERO: w_state_nxt = annul_i ? S_FREE : S_END;
      S_ON: begin
        if (annul_i)     w_state_nxt = S_FREE;
        else if (w_last) w_state_nxt = S_END;
      end
      S_END:   w_state_nxt = S_FREE;
      default: w_state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FREE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_work    <= '0;
      r_divisor <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_FREE: begin
          if (w_accept && opdata2_i != '0) begin
            r_work    <= {{DATA_W{1'b0}}, w_op1_abs, 1'b0};
            r_divisor <= w_op2_abs;
            r_cnt     <= '0;
            r_sign_q  <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_sign_r  <= signed_i & opdata1_i[DATA_W-1];
          end
        end
        S_BY_ZERO: begin
          if (!annul_i) r_result <= '0;
        end
        S_ON: begin
          if (!annul_i) begin
            r_work <= w_work_nxt;
            r_cnt  <= r_cnt + CNT_W'(1);
            if (w_last) r_result <= {w_rem, w_quot};
          end
        end
        default: ;
      endcase
    end
  end

  assign result_o   = r_result;
  assign ready_o    = (r_state == S_END);
  assign stallreq_o = start_i & ~ready_o & ~rst;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed bench for ex_div_unit: expected results and ready cycles are queued
// at issue and popped by a monitor when ready_o pulses.
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst, start_i, signed_i, annul_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;

  ex_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;

  typedef struct {logic [63:0] res; int cyc;} exp_t;
  exp_t        sb[$];
  exp_t        e_mon;
  logic [63:0] last_res;

  function automatic logic [63:0] model(input logic [31:0] n, input logic [31:0] d, input logic s);
    longint a, b, q, r;
    if (d == 32'd0) return 64'd0;
    if (s) begin
      a = longint'($signed(n));
      b = longint'($signed(d));
    end else begin
      a = longint'({32'd0, n});
      b = longint'({32'd0, d});
    end
    q = a / b;
    r = a % b;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && ready_o === 1'b1) begin
      if (sb.size() == 0) check("spurious_ready", 64'(ready_o), 64'd0);
      else begin
        e_mon = sb.pop_front();
        check("result", result_o, e_mon.res);
        check("ready_cycle", 64'(cyc), 64'(e_mon.cyc));
      end
    end
  end

  // Issue at the current cycle and step through to the END cycle.
  task automatic do_div(input logic [31:0] n, input logic [31:0] d, input logic s, input logic keep);
    int   lat;
    exp_t e;
    lat       = (d == 32'd0) ? 2 : 33;
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = n;
    opdata2_i = d;
    e.res     = model(n, d, s);
    e.cyc     = cyc + lat;
    sb.push_back(e);
    last_res  = e.res;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      check("stallreq", 64'(stallreq_o), 64'(k < lat));
      if (k == 2 && lat > 2) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = ~s;
      end
      @(posedge clk); #1;
    end
    if (!keep) start_i = 1'b0;
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("idle_stallreq", 64'(stallreq_o), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0; last_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result_o, 64'd0);
    check("rst_ready", 64'(ready_o), 64'd0);
    start_i = 1'b1;
    #1;
    check("rst_stallreq", 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_div(32'd100, 32'd7, 1'b0, 1'b0);
    check("divu_100_7", result_o, {32'd2, 32'd14});
    do_div(-32'sd7, 32'd2, 1'b1, 1'b0);
    check("div_m7_2", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});
    do_div(32'd7, -32'sd2, 1'b1, 1'b0);
    do_div(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0);
    check("div_min_m1", result_o, {32'h0, 32'h80000000});
    do_div(32'd12345, 32'd0, 1'b0, 1'b0);
    check("divu_by_zero", result_o, 64'd0);
    do_div(32'hFFFFFFFF, 32'd16, 1'b0, 1'b0);
    do_div(32'hFFFFFFFF, 32'd16, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      do_div($urandom, $urandom_range(1, 32'hFFFF), i[0], 1'b0);
    end

    // Annul mid-divide in ON.
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    idle_check(40);
    check("annul_on_keeps_result", result_o, last_res);
    do_div(32'd9, 32'd3, 1'b0, 1'b0);
    check("divu_9_3", result_o, {32'd0, 32'd3});

    // Annul in BY_ZERO.
    start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd0;
    @(posedge clk); #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    annul_i = 1'b0;
    idle_check(5);
    check("annul_byzero_keeps_result", result_o, last_res);

    // Annul blocks a start in FREE.
    start_i = 1'b1; annul_i = 1'b1; opdata1_i = 32'd8; opdata2_i = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    idle_check(40);
    check("annul_free_keeps_result", result_o, last_res);

    // Reset mid-divide.
    start_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'd0);
    check("midrst_result", result_o, 64'd0);
    check("midrst_stallreq", 64'(stallreq_o), 64'd0);
    @(posedge clk); #1;
    idle_check(40);

    // Back-to-back with start_i held.
    do_div(32'd100, 32'd7, 1'b0, 1'b1);
    do_div(32'd50, 32'd5, 1'b0, 1'b0);
    check("b2b_second", result_o, {32'd0, 32'd10});

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
